// File: rtl/sdram_load_arbiter.sv
// Arbitrates SDRAM port A between the ROM loader (FIFO-buffered, one byte per NES
// phase period) and the NES CPU, and sequences the download-to-run handover.
module sdram_load_arbiter #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_HOLD = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        nes_ce,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_done,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_oe,
    input  logic [7:0]        cpu_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [7:0]        mem_din,
    output logic              ld_full,
    output logic              ld_overflow,
    output logic              busy,
    output logic              nes_reset
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(RESET_HOLD);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [HOLD_W-1:0] r_hold;
    logic              r_overflow;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;

    logic w_phase3;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign w_phase3 = (nes_ce == 2'd3);
    assign w_full   = (r_count == DEPTH_C);
    assign w_pop    = (r_state == ST_LOAD) && w_phase3 && (r_count != CNT_W'(0));
    assign w_push   = ld_wr && (!w_full || w_pop);
    assign w_drop   = ld_wr && w_full && !w_pop;

    // FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ld_addr;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= PTR_W'(0);
            r_rd_ptr   <= PTR_W'(0);
            r_count    <= CNT_W'(0);
            r_hold     <= HOLD_C;
            r_overflow <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= ADDR_W'(0);
            r_mem_din  <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            if (w_drop) r_overflow <= 1'b1;

            // Each pop opens a 4-clock write slot aligned to phases 0..3.
            if (w_pop) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_din  <= r_fifo_data[r_rd_ptr];
            end else if (w_phase3) begin
                r_mem_we   <= 1'b0;
            end

            case (r_state)
                ST_LOAD: begin
                    r_hold <= HOLD_C;
                    if (w_phase3 && ld_done && (r_count == CNT_W'(0))) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_hold != HOLD_W'(0)) r_hold <= r_hold - HOLD_W'(1);
                    if (w_phase3 && (!ld_done || (r_count != CNT_W'(0)))) r_state <= ST_LOAD;
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign mem_addr    = (r_state == ST_RUN) ? cpu_addr : r_mem_addr;
    assign mem_we      = (r_state == ST_RUN) ? cpu_we   : r_mem_we;
    assign mem_oe      = (r_state == ST_RUN) ? cpu_oe   : 1'b0;
    assign mem_din     = (r_state == ST_RUN) ? cpu_dout : r_mem_din;
    assign ld_full     = w_full;
    assign ld_overflow = r_overflow;
    assign busy        = (r_state == ST_LOAD);
    assign nes_reset   = (r_state == ST_LOAD) || (r_hold != HOLD_W'(0));

endmodule

// File: tb/tb_sdram_load_arbiter.sv
// Directed bench for sdram_load_arbiter: loader writes are checked against a
// scoreboard queue at each slot start, control behaviour with immediate assertions.
module tb_sdram_load_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  nes_ce;
    logic        ld_wr;
    logic [21:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic [21:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_oe;
    logic [7:0]  cpu_dout;
    logic [21:0] mem_addr;
    logic        mem_we;
    logic        mem_oe;
    logic [7:0]  mem_din;
    logic        ld_full;
    logic        ld_overflow;
    logic        busy;
    logic        nes_reset;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  n;
    int  gaps;

    always #5 clk = ~clk;

    sdram_load_arbiter #(.ADDR_W(22), .FIFO_DEPTH(4), .RESET_HOLD(255)) dut (
        .clk(clk), .resetn(resetn), .nes_ce(nes_ce),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_oe(cpu_oe), .cpu_dout(cpu_dout),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din),
        .ld_full(ld_full), .ld_overflow(ld_overflow), .busy(busy), .nes_reset(nes_reset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, compare slot starts against the scoreboard,
    // then advance the phase and release the loader strobe.
    task automatic tick();
        logic [1:0] prev_ce;
        wr_t        e;
        prev_ce = nes_ce;
        @(posedge clk);
        #1;
        if (prev_ce == 2'd3 && busy && mem_we) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_din), 32'(e.data));
            end
        end
        ld_wr  = 1'b0;
        nes_ce = nes_ce + 2'd1;
    endtask

    task automatic wait_ce(input logic [1:0] v);
        for (int i = 0; i < 4 && nes_ce != v; i++) tick();
    endtask

    task automatic write_byte(input logic [21:0] a, input logic [7:0] d, input bit expect_write);
        wr_t e;
        ld_wr   = 1'b1;
        ld_addr = a;
        ld_data = d;
        e.addr  = a;
        e.data  = d;
        if (expect_write) sb.push_back(e);
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"},   32'(mem_we), 32'd0);
        chk({tag, "_oe"},   32'(mem_oe), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_din"},  32'(mem_din), 32'd0);
        chk({tag, "_full"}, 32'(ld_full), 32'd0);
        chk({tag, "_ovf"},  32'(ld_overflow), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nrst"}, 32'(nes_reset), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; nes_ce = 2'd0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        ld_done = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_oe = 1'b0; cpu_dout = '0;
        repeat (3) tick();
        check_reset("rst");
        resetn = 1'b1;

        // Single write at the phase-2 edge: slot covers the next phases 0..3.
        wait_ce(2'd2);
        write_byte(22'h000010, 8'hA5, 1'b1);
        chk("sw_pre_we", 32'(mem_we), 32'd0);
        tick();
        chk("sw_slot_phase", 32'(nes_ce), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("sw_we", 32'(mem_we), 32'd1);
            chk("sw_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("sw_we_end", 32'(mem_we), 32'd0);

        // Six back-to-back bytes from phase 0: byte 1 pops with byte 4's push,
        // byte 5 fills the FIFO, byte 6 arrives at phase 1 while full and is dropped.
        for (int i = 0; i < 6; i++) begin
            write_byte(22'(32'h100 + i), 8'(8'h30 + i), i < 5);
            if (i == 4) chk("burst_full", 32'(ld_full), 32'd1);
        end
        chk("burst_ovf", 32'(ld_overflow), 32'd1);
        chk("burst_we_on", 32'(mem_we), 32'd1);
        gaps = 0;
        repeat (17) begin
            tick();
            if (mem_we !== 1'b1) gaps++;
        end
        chk("burst_gaps", 32'(gaps), 32'd0);
        tick();
        chk("burst_we_end", 32'(mem_we), 32'd0);
        chk("burst_sb_empty", 32'(sb.size()), 32'd0);
        chk("burst_full_clr", 32'(ld_full), 32'd0);

        // Handover blocked by two queued bytes.
        cpu_addr = 22'h3FFFFF; cpu_oe = 1'b1; cpu_we = 1'b0; cpu_dout = 8'h5A;
        ld_done = 1'b1;
        write_byte(22'h000200, 8'h11, 1'b1);
        write_byte(22'h000201, 8'h22, 1'b1);
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("blk_cycles", 32'(n), 32'd10);
        chk("blk_sb_empty", 32'(sb.size()), 32'd0);
        chk("ho_phase", 32'(nes_ce), 32'd0);
        chk("ho_addr", 32'(mem_addr), 32'h3FFFFF);
        chk("ho_oe", 32'(mem_oe), 32'd1);
        chk("ho_we", 32'(mem_we), 32'd0);
        chk("ho_din", 32'(mem_din), 32'h5A);
        chk("ho_nrst", 32'(nes_reset), 32'd1);
        cpu_we = 1'b1; cpu_dout = 8'h77;
        #1;
        chk("pt_we", 32'(mem_we), 32'd1);
        chk("pt_din", 32'(mem_din), 32'h77);
        cpu_we = 1'b0;
        n = 0;
        while (nes_reset && n < 300) begin tick(); n++; end
        chk("ho_hold", 32'(n), 32'd255);

        // Redownload.
        ld_done = 1'b0;
        n = 0;
        while (!busy && n < 8) begin tick(); n++; end
        chk("rd_within4", 32'(n >= 1 && n <= 4), 32'd1);
        chk("rd_nrst", 32'(nes_reset), 32'd1);
        chk("rd_oe", 32'(mem_oe), 32'd0);
        wait_ce(2'd2);
        write_byte(22'h000300, 8'h5C, 1'b1);
        tick();
        chk("rd_we", 32'(mem_we), 32'd1);

        // Unblocked handover: FIFO empty, RUN at the slot-closing phase-3 edge.
        ld_done = 1'b1;
        n = 0;
        while (busy && n < 12) begin tick(); n++; end
        chk("ho2_cycles", 32'(n), 32'd4);
        chk("ho2_phase", 32'(nes_ce), 32'd0);
        chk("ho2_addr", 32'(mem_addr), 32'h3FFFFF);
        chk("ho2_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during phase 1 of a write slot.
        ld_done = 1'b0;
        n = 0;
        while (!busy && n < 8) begin tick(); n++; end
        wait_ce(2'd2);
        write_byte(22'h0003AB, 8'hE7, 1'b1);
        tick();
        chk("mr_we", 32'(mem_we), 32'd1);
        chk("mr_ovf_sticky", 32'(ld_overflow), 32'd1);
        tick();
        resetn  = 1'b0;
        ld_wr   = 1'b1;
        ld_addr = 22'h0003CC;
        ld_data = 8'h99;
        tick();
        check_reset("midrst");
        resetn = 1'b1;
        repeat (8) tick();
        chk("mr_no_write", 32'(mem_we), 32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
